// File: rtl/diagnosis_rx_pkg.sv
// Shared definitions for the diagnosis snapshot receiver: flit types,
// snapshot class code, parser states and the event record layout.
`ifndef DIAGNOSIS_EV_ID_WIDTH
`define DIAGNOSIS_EV_ID_WIDTH 16
`endif
`ifndef DIAGNOSIS_TIMESTAMP_WIDTH
`define DIAGNOSIS_TIMESTAMP_WIDTH 32
`endif

package diagnosis_rx_pkg;

    // lisnoc16 flit types
    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    // Class code carried in HEAD content[10:8], shared with the packetizer
    localparam logic [2:0] SNAPSHOT_CLASS = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRC,
        S_EVID,
        S_TSHI,
        S_TSLO,
        S_DHI,
        S_DLO,
        S_DRAIN
    } rx_state_t;

    // Event record at full field widths; the top trims to its parameters
    typedef struct packed {
        logic [15:0] src;
        logic [15:0] ev_id;
        logic [31:0] tstamp;
        logic        empty;
    } snap_rec_t;

    localparam int HDR_W = $bits(snap_rec_t);

    // A HEAD flit opens a snapshot packet only with the snapshot class code
    function automatic logic is_snapshot_class(input logic [15:0] content);
        return content[10:8] == SNAPSHOT_CLASS;
    endfunction

endpackage

// File: rtl/diagnosis_rx_outreg.sv
// Single-entry valid/ready output register. It may be reloaded in the same
// cycle its current entry is taken downstream.
module diagnosis_rx_outreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Load wins over drain so a consume-and-refill cycle keeps the entry valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/diagnosis_snapshot_receiver.sv
// Host-side parser for lisnoc16 diagnosis snapshot packets: emits one event
// record per packet and a stream of 32-bit snapshot words, counts good and
// malformed packets.
module diagnosis_snapshot_receiver
    import diagnosis_rx_pkg::*;
#(
    parameter int DBG_NOC_DATA_WIDTH      = 16,
    parameter int DBG_NOC_FLIT_TYPE_WIDTH = 2,
    parameter int DBG_NOC_VCHANNELS       = 1,
    parameter int EV_ID_WIDTH             = `DIAGNOSIS_EV_ID_WIDTH,
    parameter int TIMESTAMP_WIDTH         = `DIAGNOSIS_TIMESTAMP_WIDTH
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [DBG_NOC_DATA_WIDTH+DBG_NOC_FLIT_TYPE_WIDTH-1:0] dbgnoc_in_flit,
    input  logic [DBG_NOC_VCHANNELS-1:0]                          dbgnoc_in_valid,
    output logic [DBG_NOC_VCHANNELS-1:0]                          dbgnoc_in_ready,
    output logic                                                  hdr_valid,
    input  logic                                                  hdr_ready,
    output logic [15:0]                                           hdr_src,
    output logic [EV_ID_WIDTH-1:0]                                hdr_ev_id,
    output logic [TIMESTAMP_WIDTH-1:0]                            hdr_time,
    output logic                                                  hdr_empty,
    output logic                                                  word_valid,
    input  logic                                                  word_ready,
    output logic [31:0]                                           word_data,
    output logic                                                  word_last,
    output logic [15:0]                                           pkt_cnt,
    output logic [15:0]                                           err_cnt
);

    rx_state_t r_state, w_next, w_head_next;

    logic [1:0]  w_type;
    logic [15:0] w_data;
    logic        r_rdy;
    logic        w_in_ready;
    logic        w_acc;

    logic        w_hdr_load, w_hdr_empty;
    logic        w_word_load, w_word_last;
    logic        w_err, w_pkt;

    logic [15:0] r_src, r_evid, r_thi, r_whi;
    logic [15:0] r_pkt_cnt, r_err_cnt;

    snap_rec_t   w_hdr_in, w_hdr_q;
    logic [32:0] w_word_in, w_word_q;

    assign w_type = dbgnoc_in_flit[DBG_NOC_DATA_WIDTH +: DBG_NOC_FLIT_TYPE_WIDTH];
    assign w_data = dbgnoc_in_flit[DBG_NOC_DATA_WIDTH-1:0];

    // Ready is held low through reset and comes up on the first clock after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdy <= 1'b0;
        else     r_rdy <= 1'b1;
    end

    // Stall only when the stage about to load an output register finds it
    // occupied and not being drained this cycle
    always_comb begin
        w_in_ready = r_rdy;
        if (r_state == S_TSLO && hdr_valid && !hdr_ready)   w_in_ready = 1'b0;
        if (r_state == S_DLO  && word_valid && !word_ready) w_in_ready = 1'b0;
        dbgnoc_in_ready    = '0;
        dbgnoc_in_ready[0] = w_in_ready;
    end

    assign w_acc = dbgnoc_in_valid[0] & w_in_ready;

    // Parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and per-flit actions (loads, counter events)
    always_comb begin
        w_next      = r_state;
        w_hdr_load  = 1'b0;
        w_hdr_empty = 1'b0;
        w_word_load = 1'b0;
        w_word_last = 1'b0;
        w_err       = 1'b0;
        w_pkt       = 1'b0;
        w_head_next = is_snapshot_class(w_data) ? S_SRC : S_DRAIN;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (w_type == FLIT_HEADER)      w_next = w_head_next;
                    else if (w_type == FLIT_SINGLE) w_err  = 1'b1;
                end
                S_DRAIN: begin
                    if (w_type == FLIT_LAST) w_next = S_IDLE;
                end
                default: begin
                    case (w_type)
                        // New header aborts the packet and is parsed at once
                        FLIT_HEADER: begin
                            w_err  = 1'b1;
                            w_next = w_head_next;
                        end
                        FLIT_SINGLE: begin
                            w_err  = 1'b1;
                            w_next = S_DRAIN;
                        end
                        FLIT_LAST: begin
                            w_next = S_IDLE;
                            if (r_state == S_TSLO) begin
                                w_hdr_load  = 1'b1;
                                w_hdr_empty = 1'b1;
                                w_pkt       = 1'b1;
                            end else if (r_state == S_DLO) begin
                                w_word_load = 1'b1;
                                w_word_last = 1'b1;
                                w_pkt       = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        default: begin
                            case (r_state)
                                S_SRC:  w_next = S_EVID;
                                S_EVID: w_next = S_TSHI;
                                S_TSHI: w_next = S_TSLO;
                                S_TSLO: begin
                                    w_hdr_load = 1'b1;
                                    w_next     = S_DHI;
                                end
                                S_DHI:  w_next = S_DLO;
                                S_DLO: begin
                                    w_word_load = 1'b1;
                                    w_next      = S_DHI;
                                end
                                default: w_next = S_IDLE;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    // Field latches for the header and the upper half of each word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src  <= '0;
            r_evid <= '0;
            r_thi  <= '0;
            r_whi  <= '0;
        end else if (w_acc && w_type == FLIT_PAYLOAD) begin
            case (r_state)
                S_SRC:   r_src  <= w_data;
                S_EVID:  r_evid <= w_data;
                S_TSHI:  r_thi  <= w_data;
                S_DHI:   r_whi  <= w_data;
                default: ;
            endcase
        end
    end

    // Good packets wrap, errors saturate; an error cycle never counts as good
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_err) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end else if (w_pkt) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    // Assemble the record: the low timestamp half is the flit being accepted
    always_comb begin
        w_hdr_in.src    = r_src;
        w_hdr_in.ev_id  = r_evid;
        w_hdr_in.tstamp = {r_thi, w_data};
        w_hdr_in.empty  = w_hdr_empty;
    end

    assign w_word_in = {w_word_last, r_whi, w_data};

    diagnosis_rx_outreg #(.W(HDR_W)) u_hdr_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hdr_load),
        .i_data  (w_hdr_in),
        .i_ready (hdr_ready),
        .o_valid (hdr_valid),
        .o_data  (w_hdr_q)
    );

    diagnosis_rx_outreg #(.W(33)) u_word_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_word_load),
        .i_data  (w_word_in),
        .i_ready (word_ready),
        .o_valid (word_valid),
        .o_data  (w_word_q)
    );

    assign hdr_src   = w_hdr_q.src;
    assign hdr_ev_id = w_hdr_q.ev_id[EV_ID_WIDTH-1:0];
    assign hdr_time  = w_hdr_q.tstamp[TIMESTAMP_WIDTH-1:0];
    assign hdr_empty = w_hdr_q.empty;
    assign word_last = w_word_q[32];
    assign word_data = w_word_q[31:0];
    assign pkt_cnt   = r_pkt_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_diagnosis_snapshot_receiver.sv
// Self-checking bench for diagnosis_snapshot_receiver: directed scenarios
// plus a randomized packet stream, checked against packet-level expectations.
module tb_diagnosis_snapshot_receiver;

    localparam int EVW = 16;
    localparam int TSW = 32;
    localparam logic [1:0] F_PAY  = 2'b00;
    localparam logic [1:0] F_HEAD = 2'b01;
    localparam logic [1:0] F_LAST = 2'b10;
    localparam logic [1:0] F_SGL  = 2'b11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [17:0]    flit = '0;
    logic [0:0]     in_valid = '0;
    logic [0:0]     in_ready;
    logic           hdr_valid;
    logic           hdr_ready = 1'b1;
    logic [15:0]    hdr_src;
    logic [EVW-1:0] hdr_ev_id;
    logic [TSW-1:0] hdr_time;
    logic           hdr_empty;
    logic           word_valid;
    logic           word_ready = 1'b1;
    logic [31:0]    word_data;
    logic           word_last;
    logic [15:0]    pkt_cnt, err_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int hold_until = 0;
    bit rand_rdy = 1'b0;
    int stall_cnt = 0;
    int m_pkt = 0;
    int m_err = 0;
    int hbase = 0;
    int wbase = 0;

    logic [64:0] exp_hdr[$], obs_hdr[$];
    logic [32:0] exp_word[$], obs_word[$];
    logic [31:0] wq[$];

    diagnosis_snapshot_receiver #(
        .DBG_NOC_DATA_WIDTH(16), .DBG_NOC_FLIT_TYPE_WIDTH(2), .DBG_NOC_VCHANNELS(1),
        .EV_ID_WIDTH(EVW), .TIMESTAMP_WIDTH(TSW)
    ) dut (
        .clk(clk), .rst(rst),
        .dbgnoc_in_flit(flit), .dbgnoc_in_valid(in_valid), .dbgnoc_in_ready(in_ready),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_src(hdr_src),
        .hdr_ev_id(hdr_ev_id), .hdr_time(hdr_time), .hdr_empty(hdr_empty),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_last(word_last), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream consumers: always ready, randomly ready, or word side held off
    always begin
        @(posedge clk);
        #1;
        hdr_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cyc < hold_until) word_ready = 1'b0;
        else                  word_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Capture every completed handshake; values are stable at the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (hdr_valid && hdr_ready)   obs_hdr.push_back({hdr_src, hdr_ev_id, hdr_time, hdr_empty});
            if (word_valid && word_ready) obs_word.push_back({word_last, word_data});
            if (in_valid[0] && !in_ready[0]) stall_cnt = stall_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one flit and hold it until accepted (bounded)
    task automatic send(input logic [1:0] t, input logic [15:0] d);
        bit done;
        done = 1'b0;
        flit = {t, d};
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready[0];
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", {64'd0, done}, 65'd1);
    endtask

    task automatic idle_flits();
        in_valid = 1'b0;
    endtask

    // Body of a snapshot packet after its HEAD; words come from wq
    task automatic send_snap(input logic [15:0] src, input logic [15:0] ev, input logic [31:0] ts,
                             input int n, input bit close);
        send(F_PAY, src);
        send(F_PAY, ev);
        send(F_PAY, ts[31:16]);
        if (n == 0 && close) begin
            send(F_LAST, ts[15:0]);
            exp_hdr.push_back({src, ev, ts, 1'b1});
            m_pkt++;
        end else begin
            send(F_PAY, ts[15:0]);
            exp_hdr.push_back({src, ev, ts, 1'b0});
            for (int i = 0; i < n; i++) begin
                bit lst;
                lst = close && (i == n - 1);
                send(F_PAY, wq[i][31:16]);
                send(lst ? F_LAST : F_PAY, wq[i][15:0]);
                exp_word.push_back({lst, wq[i]});
            end
            if (close) m_pkt++;
        end
    endtask

    task automatic drain();
        idle_flits();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!hdr_valid && !word_valid && cyc >= hold_until) break;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain", {63'd0, hdr_valid, word_valid}, 65'd0);
    endtask

    // Compare everything captured since the last call against expectations
    task automatic compare_all(input string tag);
        int nh, nw;
        nh = obs_hdr.size() - hbase;
        nw = obs_word.size() - wbase;
        check({tag, ":nhdr"}, 65'(nh), 65'(exp_hdr.size()));
        for (int i = 0; i < exp_hdr.size(); i++)
            if (hbase + i < obs_hdr.size()) check({tag, ":hdr"}, obs_hdr[hbase+i], exp_hdr[i]);
        check({tag, ":nword"}, 65'(nw), 65'(exp_word.size()));
        for (int i = 0; i < exp_word.size(); i++)
            if (wbase + i < obs_word.size()) check({tag, ":word"}, 65'(obs_word[wbase+i]), 65'(exp_word[i]));
        check({tag, ":pkt_cnt"}, 65'(pkt_cnt), 65'(m_pkt[15:0]));
        check({tag, ":err_cnt"}, 65'(err_cnt), 65'(m_err[15:0]));
        hbase = obs_hdr.size();
        wbase = obs_word.size();
        exp_hdr.delete();
        exp_word.delete();
    endtask

    initial begin
        int s0, kind, n;
        logic [15:0] src, ev;
        logic [31:0] ts;
        logic [2:0]  cls;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 65'(in_ready), 65'd0);
        check("rst_valids", {63'd0, hdr_valid, word_valid}, 65'd0);
        check("rst_cnts", {33'd0, pkt_cnt, err_cnt}, 65'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 65'(in_ready), 65'd1);

        // Single good packet from the test plan, with output latency checks
        send(F_HEAD, 16'h0200);
        send(F_PAY, 16'h0005);
        send(F_PAY, 16'h0003);
        send(F_PAY, 16'h1234);
        send(F_PAY, 16'h5678);
        check("hdr_latency", 65'(hdr_valid), 65'd1);
        send(F_PAY, 16'hDEAD);
        send(F_PAY, 16'hBEEF);
        check("word_latency", 65'(word_valid), 65'd1);
        send(F_PAY, 16'h0000);
        send(F_LAST, 16'h0001);
        exp_hdr.push_back({16'h0005, 16'h0003, 32'h12345678, 1'b0});
        exp_word.push_back({1'b0, 32'hDEADBEEF});
        exp_word.push_back({1'b1, 32'h00000001});
        m_pkt++;
        drain();
        compare_all("good");

        // Empty packet
        send(F_HEAD, 16'h0200);
        send_snap(16'h00A1, 16'h0042, 32'hCAFE0001, 0, 1'b1);
        drain();
        compare_all("empty");

        // Backpressure on the word side during a 4-word packet
        s0 = stall_cnt;
        wq = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        send(F_HEAD, 16'h0200);
        send(F_PAY, 16'h0BB0);
        send(F_PAY, 16'h0007);
        send(F_PAY, 16'hA5A5);
        send(F_PAY, 16'h5A5A);
        exp_hdr.push_back({16'h0BB0, 16'h0007, 32'hA5A55A5A, 1'b0});
        send(F_PAY, wq[0][31:16]);
        hold_until = cyc + 12;
        send(F_PAY, wq[0][15:0]);
        for (int i = 1; i < 4; i++) begin
            send(F_PAY, wq[i][31:16]);
            send(i == 3 ? F_LAST : F_PAY, wq[i][15:0]);
        end
        for (int i = 0; i < 4; i++) exp_word.push_back({i == 3, wq[i]});
        m_pkt++;
        drain();
        check("bp_stall_seen", 65'(stall_cnt > s0), 65'd1);
        compare_all("backpressure");

        // Foreign class: six flits ignored, then a snapshot packet parses
        send(F_HEAD, 16'h0100);
        for (int i = 0; i < 4; i++) send(F_PAY, 16'(i * 16'h1111));
        send(F_LAST, 16'h00FF);
        wq = '{32'h0BADF00D};
        send(F_HEAD, 16'h0200);
        send_snap(16'h0009, 16'h0001, 32'h00000010, 1, 1'b1);
        drain();
        compare_all("foreign");

        // Truncated in TSHI, then HEAD mid-DHI followed by a full packet
        send(F_HEAD, 16'h0200);
        send(F_PAY, 16'h0001);
        send(F_PAY, 16'h0002);
        send(F_LAST, 16'h0003);
        m_err++;
        drain();
        compare_all("trunc_tshi");
        wq = '{32'hABCD0123};
        send(F_HEAD, 16'h0200);
        send_snap(16'h0011, 16'h0022, 32'h33334444, 1, 1'b0);
        m_err++;
        wq = '{32'h01020304, 32'h05060708};
        send(F_HEAD, 16'h0200);
        send_snap(16'h0055, 16'h0066, 32'h77778888, 2, 1'b1);
        drain();
        compare_all("head_abort");

        // Randomized packet stream with random downstream readiness
        rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 2) begin
                n = $urandom_range(0, 4);
                wq.delete();
                for (int i = 0; i < n; i++) wq.push_back($urandom);
                src = 16'($urandom);
                ev  = 16'($urandom);
                ts  = $urandom;
                send(F_HEAD, {5'($urandom), 3'b010, 8'($urandom)});
                send_snap(src, ev, ts, n, 1'b1);
            end else if (kind == 3) begin
                cls = 3'($urandom_range(3, 7));
                if ($urandom_range(0, 1) == 1) cls = 3'b000;
                send(F_HEAD, {5'd0, cls, 8'($urandom)});
                n = $urandom_range(0, 5);
                for (int i = 0; i < n; i++) send(F_PAY, 16'($urandom));
                send(F_LAST, 16'($urandom));
            end else if (kind == 4) begin
                send(F_SGL, 16'($urandom));
                m_err++;
            end else begin
                send($urandom_range(0, 1) == 1 ? F_LAST : F_PAY, 16'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                idle_flits();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        drain();
        compare_all("random");

        // Asynchronous reset while parsing in DHI
        wq = '{32'h99990000};
        send(F_HEAD, 16'h0200);
        send_snap(16'h0777, 16'h0888, 32'h9999AAAA, 1, 1'b0);
        idle_flits();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valids", {63'd0, hdr_valid, word_valid}, 65'd0);
        check("arst_in_ready", 65'(in_ready), 65'd0);
        check("arst_cnts", {33'd0, pkt_cnt, err_cnt}, 65'd0);
        check("arst_data", {hdr_src, word_data, hdr_empty, word_last}, 65'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pkt = 0;
        m_err = 0;
        hbase = obs_hdr.size();
        wbase = obs_word.size();
        exp_hdr.delete();
        exp_word.delete();
        @(posedge clk);
        #1;
        send(F_PAY, 16'h1234);
        send(F_LAST, 16'h5678);
        drain();
        compare_all("after_rst");
        wq = '{32'hFEEDFACE};
        send(F_HEAD, 16'h0200);
        send_snap(16'h0123, 16'h0456, 32'h789ABCDE, 1, 1'b1);
        drain();
        compare_all("recover");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
